decoder_3_8_pipe: RTL

// - Registered binary-to-one-hot decoder: accepts an IN_W-bit code and emits a 2**IN_W-bit one-hot word.
// - Inverse of the team's 8->3 encoder; pairs with it in encode/decode loopback paths.
// - Valid/ready on both sides with a 2-entry skid buffer, so full throughput survives output stalls.

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec_onehot.sv | 23 ++
 rtl/decoder_3_8_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared constants for the registered 3->8 one-hot decoder.
//   DEC_IN_W  : default code width
//   DEC_OUT_W : one-hot width derived from DEC_IN_W
//   DEC_CNT_W : width of the optional accepted-code counter
//   ST_*      : occupancy states of the output/skid pipeline (2-bit)
package dec_pkg;

    localparam int unsigned DEC_IN_W  = 3;
    localparam int unsigned DEC_OUT_W = 1 << DEC_IN_W;
    localparam int unsigned DEC_CNT_W = 16;

    // Number of words held between the output register and the skid entry
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: purely combinational binary-to-one-hot decode.
//   code   in  IN_W       binary code
//   en     in  1          enable; 0 forces an all-zero word
//   onehot out 2**IN_W    bit 'code' set when en=1, else all zero
module dec_onehot
    import dec_pkg::*;
#(
    parameter int unsigned IN_W = DEC_IN_W
) (
    input  logic [IN_W-1:0]       code,
    input  logic                  en,
    output logic [(1<<IN_W)-1:0]  onehot
);

    // Every code value indexes a real bit, so the result is never X
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_3_8_pipe.sv
// decoder_3_8_pipe: registered binary-to-one-hot decoder with valid/ready
// handshakes and a 2-entry (output register + skid) buffer.
//   clk        in   1       clock, rising edge
//   resetn     in   1       synchronous active-low reset
//   in_valid   in   1       upstream code valid
//   in_ready   out  1       decoder accepts a code this cycle (registered)
//   in_code    in   IN_W    binary code
//   in_en      in   1       enable qualifier; 0 -> decoded word all-zero
//   out_valid  out  1       out_onehot holds a valid word
//   out_ready  in   1       downstream accepts out_onehot this cycle
//   out_onehot out  2**IN_W decoded word
//   out_cnt    out  16      accepted-code count (only with DEC_3_8_CNT_EN)
// Build option: define DEC_3_8_CNT_EN to add the wrapping accept counter.
module decoder_3_8_pipe
    import dec_pkg::*;
#(
    parameter int unsigned IN_W = DEC_IN_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_code,
    input  logic                  in_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(1<<IN_W)-1:0]  out_onehot
`ifdef DEC_3_8_CNT_EN
    ,
    output logic [DEC_CNT_W-1:0]  out_cnt
`endif
);

    localparam int unsigned OUT_W = 1 << IN_W;

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic             ready_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] skid_q;
    logic [OUT_W-1:0] decoded;
    logic             accept;
    logic             emit;
    logic             load_out_dec;
    logic             load_out_skid;
    logic             load_skid;

    dec_onehot #(
        .IN_W (IN_W)
    ) u_dec (
        .code   (in_code),
        .en     (in_en),
        .onehot (decoded)
    );

    assign accept     = in_valid & ready_q;
    assign emit       = out_valid & out_ready;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_onehot = out_q;
    assign in_ready   = ready_q;

    // ready_q is low only in ST_TWO, so no accept can arrive while the skid is full
    always_comb begin
        state_nxt     = state_q;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_ONE;
                    load_out_dec = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    load_out_dec = 1'b1;
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    state_nxt     = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt != ST_TWO);
            if (load_out_dec) begin
                out_q <= decoded;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= decoded;
            end
        end
    end

`ifdef DEC_3_8_CNT_EN
    logic [DEC_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_cnt = cnt_q;
`endif

endmodule
